// File: rtl/seq_div8_core.sv
// rtl/seq_div8_core.sv - sequential radix-2 restoring divider, signed/unsigned/mixed operands
// Optional macro SEQ_DIV_ZERO_FAST_EN: short-circuit divide-by-zero straight to FIX.
module seq_div8_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       sign_mode,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             sign_a, sign_b, b_zero;
    logic [WIDTH-1:0] mag_b, q, rem, a_raw;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             sign_a_in, sign_b_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   rem_sh, diff;
    logic             fix_go;

    assign accept    = (state == IDLE) && start;
    assign sign_a_in = sign_mode[1] & dividend[WIDTH-1];
    assign sign_b_in = sign_mode[0] & divisor[WIDTH-1];
    // Two's-complement negate of the most negative value wraps to itself, which is its unsigned magnitude.
    assign mag_a_in  = sign_a_in ? -dividend : dividend;
    assign mag_b_in  = sign_b_in ? -divisor  : divisor;

    // The partial remainder stays below |B| between iterations, so only the shifted value needs the extra bit.
    assign rem_sh = {rem, q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, mag_b};

`ifdef SEQ_DIV_ZERO_FAST_EN
    logic fix_hold;
    assign fix_go = (state == FIX) && !fix_hold;
`else
    assign fix_go = (state == FIX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SEQ_DIV_ZERO_FAST_EN
                    state_nxt = (divisor == '0) ? FIX : ITER;
`else
                    state_nxt = ITER;
`endif
                end
            end
            ITER: begin
                if (cnt == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                if (fix_go) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
            mag_b       <= '0;
            q           <= '0;
            rem         <= '0;
            a_raw       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_ZERO_FAST_EN
            fix_hold    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                sign_a <= sign_a_in;
                sign_b <= sign_b_in;
                b_zero <= (divisor == '0);
                mag_b  <= mag_b_in;
                q      <= mag_a_in;
                rem    <= '0;
                a_raw  <= dividend;
                cnt    <= CW'(WIDTH);
                busy   <= 1'b1;
`ifdef SEQ_DIV_ZERO_FAST_EN
                // The fast path still spends one cycle in FIX so done lands two edges after acceptance.
                fix_hold <= (divisor == '0);
`endif
            end else if (state == ITER) begin
                cnt <= cnt - CW'(1);
                if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else if (fix_go) begin
                if (b_zero) begin
                    quotient  <= '1;
                    remainder <= a_raw;
                end else begin
                    quotient  <= (sign_a ^ sign_b) ? -q : q;
                    remainder <= sign_a ? -rem : rem;
                end
                div_by_zero <= b_zero;
                done        <= 1'b1;
                busy        <= 1'b0;
            end
`ifdef SEQ_DIV_ZERO_FAST_EN
            else if (state == FIX) begin
                fix_hold <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_div8_core.sv
// tb/tb_seq_div8_core.sv - directed self-checking bench for seq_div8_core
module tb_seq_div8_core;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend, divisor;
    logic [1:0] sign_mode;
    logic [7:0] quotient, remainder;
    logic       done, busy, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int pulses;

`ifdef SEQ_DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 9;
`endif

    seq_div8_core #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .sign_mode   (sign_mode),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge following the accepting edge; returns edges until done.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] m, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input int elat);
        int e;
        @(negedge clk);
        dividend = a; divisor = b; sign_mode = m; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(tag, e);
        check({tag, "_lat"}, e, elat);
        check({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
        check({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
        check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        dividend = '0; divisor = '0; sign_mode = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {13'd0, quotient, remainder, done, busy, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run_op("u_200_7",   8'hC8, 8'h07, 2'b00, 8'h1C, 8'h04, 1'b0, 9);
        run_op("s_m100_7",  8'h9C, 8'h07, 2'b11, 8'hF2, 8'hFE, 1'b0, 9);
        run_op("s_ovf",     8'h80, 8'hFF, 2'b11, 8'h80, 8'h00, 1'b0, 9);
        run_op("mx_m10_3",  8'hF6, 8'h03, 2'b10, 8'hFD, 8'hFF, 1'b0, 9);
        run_op("u_246_3",   8'hF6, 8'h03, 2'b00, 8'h52, 8'h00, 1'b0, 9);
        run_op("mx_255_m1", 8'hFF, 8'hFF, 2'b01, 8'h01, 8'h00, 1'b0, 9);
        run_op("dz",        8'h55, 8'h00, 2'b11, 8'hFF, 8'h55, 1'b1, DZ_LAT);
        run_op("dz_clear",  8'h0A, 8'h02, 2'b00, 8'h05, 8'h00, 1'b0, 9);

        // Outputs hold across acceptance; a start mid-op is ignored.
        @(negedge clk);
        dividend = 8'h64; divisor = 8'h0A; sign_mode = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("hold_q", {24'd0, quotient}, 32'h05);
        repeat (2) @(negedge clk);
        dividend = 8'hC8; divisor = 8'h07; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                check("ign_q", {24'd0, quotient}, 32'h0A);
                check("ign_r", {24'd0, remainder}, 32'h00);
            end
            @(negedge clk);
        end
        check("ign_pulses", pulses, 1);

        // Back-to-back: start held through done cycle.
        dividend = 8'h0F; divisor = 8'h04; sign_mode = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done("b2b1", lat);
        check("b2b1_q", {24'd0, quotient}, 32'h03);
        check("b2b1_r", {24'd0, remainder}, 32'h03);
        dividend = 8'h9C; divisor = 8'h0A; sign_mode = 2'b11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b2", lat);
        check("b2b2_lat", lat, 9);
        check("b2b2_q", {24'd0, quotient}, 32'hF6);
        check("b2b2_r", {24'd0, remainder}, 32'h00);

        // Reset mid-operation.
        @(negedge clk);
        dividend = 8'h9C; divisor = 8'h07; sign_mode = 2'b11; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_mid", {13'd0, quotient, remainder, done, busy, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("rst_no_done", pulses, 0);
        run_op("post_rst", 8'hC8, 8'h07, 2'b00, 8'h1C, 8'h04, 1'b0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
